sram_req_arbiter: RTL and testbench

- Shares one downstream SRAM-like memory port between the instruction-fetch requester (master 0) and the load/store requester (master 1).
- Selects one request per cycle and locks the grant until the request is accepted.
- Records the source of every accepted request in an in-order ID FIFO, and routes each data_ok/rdata return to its owner.
- Sits between the IF/MEM stages and the SRAM-to-AXI bridge.

---
 rtl/sram_arb_pkg.sv | 11 +
 rtl/arb_id_fifo.sv | 52 +++++
 rtl/sram_req_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_req_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM request arbiter: requester IDs and transfer size encodings.
package sram_arb_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per accepted-but-unreturned request.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter onto one SRAM-like port with grant lock and in-order return routing.
// Define ARB_RR_EN for round-robin selection; default is fixed priority (data over inst).
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [1:0]        m0_size,
    input  logic [3:0]        m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [1:0]        m1_size,
    input  logic [3:0]        m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [3:0]        s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              orphan_err
);

    logic                   grant;
    logic                   lock;
    logic                   locked_src;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_head;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   accept;
    logic                   pop;

`ifdef ARB_RR_EN
    logic last_grant;
`endif

    // A stalled request keeps its grant so the downstream fields stay stable.
    always_comb begin
        grant = SRC_INST;
        if (lock)
            grant = locked_src;
        else if (m0_req && m1_req)
`ifdef ARB_RR_EN
            grant = ~last_grant;
`else
            grant = SRC_DATA;
`endif
        else if (m1_req)
            grant = SRC_DATA;
    end

    assign s_req  = (m0_req | m1_req) & ~fifo_full;
    assign accept = s_req & s_addr_ok;
    assign pop    = s_data_ok & ~fifo_empty;

    assign s_wr    = (grant == SRC_DATA) ? m1_wr    : m0_wr;
    assign s_size  = (grant == SRC_DATA) ? m1_size  : m0_size;
    assign s_wstrb = (grant == SRC_DATA) ? m1_wstrb : m0_wstrb;
    assign s_addr  = (grant == SRC_DATA) ? m1_addr  : m0_addr;
    assign s_wdata = (grant == SRC_DATA) ? m1_wdata : m0_wdata;

    assign m0_addr_ok = accept & (grant == SRC_INST);
    assign m1_addr_ok = accept & (grant == SRC_DATA);
    assign m0_data_ok = pop & (fifo_head == SRC_INST);
    assign m1_data_ok = pop & (fifo_head == SRC_DATA);
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign busy       = (fifo_count != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock       <= 1'b0;
            locked_src <= SRC_INST;
        end else if (s_req) begin
            lock       <= ~s_addr_ok;
            locked_src <= grant;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            last_grant <= SRC_INST;
        else if (accept)
            last_grant <= grant;
    end
`endif

    // A return with nothing outstanding belongs to no one; it is flagged, never routed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            orphan_err <= 1'b0;
        else if (s_data_ok && fifo_empty)
            orphan_err <= 1'b1;
    end

    arb_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter against a queue-based model of the arbitration rules.
module tb_sram_req_arbiter;

    localparam int DEPTH = 4;

    logic        clk;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        busy, orphan_err;

    int checks = 0;
    int errors = 0;

    bit q[$];
    bit mdl_lock, mdl_src, mdl_last, mdl_orphan;
    bit pend0, pend1, last_r0, last_r1, last_acc0, last_acc1;

    sram_req_arbiter #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .busy(busy), .orphan_err(orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic new_fields(input bit m);
        if (!m) begin
            m0_wr = 1'($urandom); m0_size = 2'($urandom_range(0, 2));
            m0_wstrb = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
        end else begin
            m1_wr = 1'($urandom); m1_size = 2'($urandom_range(0, 2));
            m1_wstrb = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
        end
    endtask

    task automatic model_reset();
        q.delete();
        mdl_lock = 0; mdl_src = 0; mdl_last = 0; mdl_orphan = 0;
        pend0 = 0; pend1 = 0; last_r0 = 0; last_r1 = 0; last_acc0 = 0; last_acc1 = 0;
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model.
    task automatic apply_stimulus(input bit r0, input bit r1, input bit aok, input bit dok, input logic [31:0] rd);
        bit g, sreq, pop, head, acc;
        @(negedge clk);
        if (pend0) new_fields(0);
        if (pend1) new_fields(1);
        pend0 = 0; pend1 = 0;
        m0_req = r0; m1_req = r1; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
        #1;
        if (mdl_lock)
            g = mdl_src;
        else if (r0 && r1) begin
`ifdef ARB_RR_EN
            g = !mdl_last;
`else
            g = 1'b1;
`endif
        end else
            g = r1;
        sreq = (r0 || r1) && (q.size() < DEPTH);
        acc  = sreq && aok;
        pop  = dok && (q.size() != 0);
        head = (q.size() != 0) ? q[0] : 1'b0;

        check_output("s_req", s_req, sreq);
        if (sreq) begin
            check_output("s_addr", s_addr, g ? m1_addr : m0_addr);
            check_output("s_fields", {s_wr, s_size, s_wstrb, s_wdata},
                         g ? {m1_wr, m1_size, m1_wstrb, m1_wdata} : {m0_wr, m0_size, m0_wstrb, m0_wdata});
        end
        check_output("m0_addr_ok", m0_addr_ok, acc && !g);
        check_output("m1_addr_ok", m1_addr_ok, acc && g);
        check_output("m0_data_ok", m0_data_ok, pop && !head);
        check_output("m1_data_ok", m1_data_ok, pop && head);
        if (dok) begin
            check_output("m0_rdata", m0_rdata, rd);
            check_output("m1_rdata", m1_rdata, rd);
        end
        check_output("busy", busy, q.size() != 0);
        check_output("orphan_err", orphan_err, mdl_orphan);

        if (dok && !pop) mdl_orphan = 1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(g);
            mdl_last = g;
            if (g) pend1 = 1; else pend0 = 1;
        end
        if (sreq) begin
            mdl_lock = !aok;
            mdl_src  = g;
        end
        last_r0 = r0; last_r1 = r1;
        last_acc0 = acc && !g; last_acc1 = acc && g;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++)
            apply_stimulus(0, 0, 0, 1, $urandom);
    endtask

    initial begin
        resetn = 0;
        m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
        m0_wr = 0; m0_size = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
        m1_wr = 0; m1_size = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_output("rst_s_req", s_req, 0);
        check_output("rst_addr_ok", {m0_addr_ok, m1_addr_ok}, 0);
        check_output("rst_data_ok", {m0_data_ok, m1_data_ok}, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_orphan", orphan_err, 0);
        check_output("rst_s_addr", s_addr, 0);
        @(negedge clk); resetn = 1;
        new_fields(0); new_fields(1);

        $display("[TB] contention with immediate accept");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 1, 1, i >= 2, 32'h100 + i);
`ifdef ARB_RR_EN
            check_output("rr_alternate", m1_addr_ok, (i % 2) == 0);
`else
            check_output("m0_starved", m0_addr_ok, 0);
`endif
        end
        drain();

        $display("[TB] stalled grant holds");
        m1_addr = 32'h1c000100;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i >= 1, 1, i == 3, 0, 0);
            check_output("stall_s_addr", s_addr, 32'h1c000100);
            check_output("stall_m1_ok", m1_addr_ok, i == 3);
        end
        apply_stimulus(1, 0, 1, 0, 0);
        drain();

        $display("[TB] in-order return routing");
        apply_stimulus(1, 0, 1, 0, 0);
        apply_stimulus(0, 1, 1, 0, 0);
        apply_stimulus(1, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 32'hA);
        check_output("ret_a_m0", {m0_data_ok, m1_data_ok, m0_rdata}, {2'b10, 32'hA});
        apply_stimulus(0, 0, 0, 1, 32'hB);
        check_output("ret_b_m1", {m0_data_ok, m1_data_ok, m1_rdata}, {2'b01, 32'hB});
        apply_stimulus(0, 0, 0, 1, 32'hC);
        check_output("ret_c_m0", {m0_data_ok, m1_data_ok, m0_rdata}, {2'b10, 32'hC});
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("busy_drop", busy, 0);

        $display("[TB] full FIFO blocks requests");
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 0, 1, 0, 0);
        apply_stimulus(1, 1, 1, 0, 0);
        check_output("full_s_req", s_req, 0);
        check_output("full_addr_ok", {m0_addr_ok, m1_addr_ok}, 0);
        apply_stimulus(1, 0, 1, 1, 32'h55);
        check_output("full_pop_s_req", s_req, 0);
        apply_stimulus(1, 0, 1, 0, 0);
        check_output("after_pop_accept", m0_addr_ok, 1);
        drain();

        $display("[TB] orphan return and async reset");
        apply_stimulus(0, 0, 0, 1, 32'h77);
        check_output("orphan_no_ok", {m0_data_ok, m1_data_ok}, 0);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("orphan_set", orphan_err, 1);
        apply_stimulus(1, 0, 1, 1, 32'h78);
        apply_stimulus(0, 0, 0, 0, 0);
        check_output("orphan_held", orphan_err, 1);
        check_output("busy_mid", busy, 1);
        #2 resetn = 0;
        #1;
        check_output("async_busy", busy, 0);
        check_output("async_orphan", orphan_err, 0);
        model_reset();
        @(negedge clk); resetn = 1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            bit r0, r1;
            r0 = (last_r0 && !last_acc0) ? 1'b1 : 1'($urandom_range(0, 1));
            r1 = (last_r1 && !last_acc1) ? 1'b1 : 1'($urandom_range(0, 1));
            apply_stimulus(r0, r1, $urandom_range(0, 3) != 0,
                           (q.size() != 0) && ($urandom_range(0, 1) == 1), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
